// File: rtl/ahb5_interface.sv
// AHB5 single-master bridge: SINGLE/INCR4 commands become pipelined AHB5 transfers.
// Latency: address phase the cycle after accept; response pulse the cycle after each data phase.
// Backpressure: cmd_ready only while idle; HREADY low stalls the address and data stages together.
module ahb5_interface #(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter logic [3:0] HMASTER_ID = 4'h0
) (
    input  logic                Hclk,
    input  logic                HResetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2:0]          cmd_size,
    input  logic                cmd_burst,
    input  logic [4*DATA_W-1:0] cmd_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_last,
    output logic [ADDR_W-1:0]   HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic [DATA_W-1:0]   HWDATA,
    output logic                HMASTLOCK,
    output logic                HNONSEC,
    output logic                HEXCL,
    output logic [3:0]          HMASTER,
    input  logic [DATA_W-1:0]   HRDATA,
    input  logic                HREADY,
    input  logic                HRESP,
    input  logic                HEXOKAY
);
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

    state_t              state;
    logic [1:0]          abeat;
    logic [1:0]          dbeat;
    logic [1:0]          last_beat;
    logic [4*DATA_W-1:0] wbuf;
    logic [2:0]          csize;
    logic [ADDR_W-1:0]   cmd_aligned;
    logic [ADDR_W-1:0]   next_addr;
    logic                more;
    logic                issue;
    logic                unused_hexokay;

    assign unused_hexokay = HEXOKAY;

    assign cmd_ready = (state == S_IDLE) && !HResetn;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign HNONSEC   = 1'b0;
    assign HEXCL     = 1'b0;
    assign HMASTER   = HMASTER_ID;

    assign csize = (cmd_size > 3'd2) ? 3'd2 : cmd_size;

    always_comb begin
        cmd_aligned = cmd_addr;
        if (csize == 3'd1)
            cmd_aligned[0] = 1'b0;
        else if (csize == 3'd2)
            cmd_aligned[1:0] = 2'b00;
    end

    assign next_addr = HADDR + (ADDR_W'(1) << HSIZE);
    assign more      = (abeat != last_beat);

    // The address phase on the bus completes now: its data phase starts and the next beat is presented.
    assign issue = HREADY && !HRESP &&
                   ((state == S_ADDR) || ((state == S_DATA) && (HTRANS != T_IDLE)));

    always_ff @(posedge Hclk or posedge HResetn) begin
        if (HResetn) begin
            state     <= S_IDLE;
            HTRANS    <= T_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'd0;
            HBURST    <= 3'd0;
            HWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            abeat     <= 2'd0;
            dbeat     <= 2'd0;
            last_beat <= 2'd0;
            wbuf      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        HTRANS    <= T_NONSEQ;
                        HADDR     <= cmd_aligned;
                        HWRITE    <= cmd_write;
                        HSIZE     <= csize;
                        HBURST    <= cmd_burst ? 3'b011 : 3'b000;
                        last_beat <= cmd_burst ? 2'd3 : 2'd0;
                        abeat     <= 2'd0;
                        wbuf      <= cmd_wdata;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (HREADY && !HRESP)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (HRESP && !HREADY) begin
                        // First error cycle: cancel whatever beat is pending in the address stage.
                        HTRANS <= T_IDLE;
                        state  <= S_ERR;
                    end else if (HREADY) begin
                        rsp_valid <= 1'b1;
                        if (HRESP) begin
                            rsp_err  <= 1'b1;
                            rsp_last <= 1'b1;
                            HTRANS   <= T_IDLE;
                            HWDATA   <= '0;
                            state    <= S_IDLE;
                        end else begin
                            rsp_rdata <= HWRITE ? '0 : HRDATA;
                            rsp_last  <= (dbeat == last_beat);
                            if (HTRANS == T_IDLE) begin
                                HWDATA <= '0;
                                state  <= S_IDLE;
                            end
                        end
                    end
                end
                S_ERR: begin
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        HWDATA    <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (issue) begin
                dbeat  <= abeat;
                HWDATA <= HWRITE ? wbuf[int'(abeat)*DATA_W +: DATA_W] : '0;
                if (more) begin
                    abeat  <= abeat + 2'd1;
                    HADDR  <= next_addr;
                    HTRANS <= (next_addr[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
                end else begin
                    HTRANS <= T_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb5_interface.sv
// Bench for ahb5_interface: a cycle-level AHB slave plus a transaction-level model of each command.
module tb_ahb5_interface;
    typedef struct packed {
        logic [31:0] d;
        logic        err;
        logic        last;
    } rsp_t;

    logic         Hclk = 1'b0;
    logic         HResetn = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_write = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [2:0]   cmd_size = '0;
    logic         cmd_burst = 1'b0;
    logic [127:0] cmd_wdata = '0;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         rsp_last;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    logic [31:0]  HWDATA;
    logic         HMASTLOCK;
    logic         HNONSEC;
    logic         HEXCL;
    logic [3:0]   HMASTER;
    logic [31:0]  HRDATA = '0;
    logic         HREADY = 1'b1;
    logic         HRESP = 1'b0;
    logic         HEXOKAY = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Per-command model state
    logic [31:0] e_addr[4];
    logic [1:0]  e_trans[4];
    logic [2:0]  e_sz;
    logic [2:0]  e_bst;
    int          e_nb;
    int          e_n;
    rsp_t        exp_q[$];
    logic [31:0] rd_val[4];
    logic [31:0] wd[4];
    int          ws[4];

    always #5 Hclk = ~Hclk;

    ahb5_interface #(.ADDR_W(32), .DATA_W(32), .HMASTER_ID(4'hA)) dut (
        .Hclk(Hclk), .HResetn(HResetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HWDATA(HWDATA), .HMASTLOCK(HMASTLOCK), .HNONSEC(HNONSEC),
        .HEXCL(HEXCL), .HMASTER(HMASTER),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .HEXOKAY(HEXOKAY)
    );

    // Transaction-level expectation: beat addresses, transfer types and the response list.
    task automatic model(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic bu, input int err_beat);
        logic [31:0] step;
        logic [31:0] base;
        rsp_t        r;
        e_sz  = (sz > 3'd2) ? 3'd2 : sz;
        e_bst = bu ? 3'b011 : 3'b000;
        e_nb  = bu ? 4 : 1;
        step  = 32'd1 << e_sz;
        base  = a - (a % step);
        e_n   = (err_beat >= 0 && err_beat < e_nb) ? err_beat + 1 : e_nb;
        exp_q.delete();
        for (int i = 0; i < e_nb; i++) begin
            e_addr[i]  = base + step * 32'(i);
            e_trans[i] = (i == 0 || (e_addr[i] % 1024) == 0) ? 2'b10 : 2'b11;
        end
        for (int i = 0; i < e_n; i++) begin
            if (i == err_beat)
                r = '{d: 32'h0, err: 1'b1, last: 1'b1};
            else
                r = '{d: (wr ? 32'h0 : rd_val[i]), err: 1'b0, last: (i == e_nb - 1)};
            exp_q.push_back(r);
        end
    endtask

    task automatic rand_slave(input int maxws);
        for (int i = 0; i < 4; i++) begin
            rd_val[i] = $urandom;
            ws[i]     = $urandom_range(0, maxws);
        end
    endtask

    // Issue one command and play the slave side cycle by cycle, checking against the model.
    task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic bu, input logic [127:0] wdat,
                           input int err_beat, input int abort_at);
        int   k = 0;
        int   di = 0;
        int   dw = 0;
        int   cyc = 0;
        bit   dp = 0;
        bit   esn = 0;
        bit   done = 0;
        bit   due = 0;
        bit   fin = 0;
        rsp_t r;
        model(wr, a, sz, bu, err_beat);
        for (int i = 0; i < 4; i++) wd[i] = wdat[i*32 +: 32];
        @(negedge Hclk);
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz;
        cmd_burst = bu; cmd_wdata = wdat;
        while (!fin && cyc < 100) begin
            @(negedge Hclk);
            cyc++;
            if (cyc == abort_at) begin
                #2 HResetn = 1'b1;
                #1;
                n_chk++;
                if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, cmd_ready,
                     rsp_valid, rsp_rdata, rsp_err, rsp_last} !== '0) begin
                    n_fail++;
                    $display("FAIL abort_reset: got trans=%h addr=%h wdata=%h rdy=%b rsp=%b expected all zero",
                             HTRANS, HADDR, HWDATA, cmd_ready, rsp_valid);
                end
                cmd_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
                return;
            end
            // Junk commands while busy must be ignored.
            cmd_valid = cmd_ready ? 1'b0 : 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_size  = 3'($urandom_range(0, 7));
            cmd_burst = 1'($urandom_range(0, 1));
            cmd_wdata = {$urandom, $urandom, $urandom, $urandom};
            if (cyc == 1) begin
                n_chk++;
                if (HTRANS !== 2'b10) begin
                    n_fail++;
                    $display("FAIL first_addr_latency: got HTRANS=%b expected 10", HTRANS);
                end
            end
            n_chk++;
            if (rsp_valid !== due) begin
                n_fail++;
                $display("FAIL rsp_timing: got rsp_valid=%b expected %b", rsp_valid, due);
            end
            if (rsp_valid === 1'b1) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_extra: got rdata=%h err=%b last=%b expected none",
                             rsp_rdata, rsp_err, rsp_last);
                end else begin
                    r = exp_q.pop_front();
                    if ({rsp_rdata, rsp_err, rsp_last} !== r) begin
                        n_fail++;
                        $display("FAIL rsp_value: got %h/%b/%b expected %h/%b/%b",
                                 rsp_rdata, rsp_err, rsp_last, r.d, r.err, r.last);
                    end
                    fin = (exp_q.size() == 0);
                end
            end
            due = 0;
            if (fin) begin
                HREADY = 1'b1; HRESP = 1'b0;
                n_chk++;
                if ({HTRANS, HWDATA, cmd_ready} !== {2'b00, 32'h0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL end_idle: got trans=%b wdata=%h rdy=%b expected 00/0/1",
                             HTRANS, HWDATA, cmd_ready);
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom; done = 0;
                n_chk++;
                if (HWDATA !== ((dp && wr) ? wd[di] : 32'h0)) begin
                    n_fail++;
                    $display("FAIL hwdata: got %h expected %h (beat %0d)", HWDATA,
                             ((dp && wr) ? wd[di] : 32'h0), di);
                end
                if (dp) begin
                    if (di == err_beat) begin
                        if (!esn) begin
                            HREADY = 1'b0; HRESP = 1'b1; esn = 1;
                        end else begin
                            n_chk++;
                            if (HTRANS !== 2'b00) begin
                                n_fail++;
                                $display("FAIL err_cancel: got HTRANS=%b expected 00", HTRANS);
                            end
                            HRESP = 1'b1; done = 1;
                        end
                    end else if (dw > 0) begin
                        HREADY = 1'b0; dw--;
                    end else begin
                        HRDATA = rd_val[di]; done = 1;
                    end
                end
                if (HTRANS !== 2'b00) begin
                    n_chk++;
                    if (k >= e_nb) begin
                        n_fail++;
                        $display("FAIL extra_beat: got HTRANS=%b addr=%h expected idle", HTRANS, HADDR);
                    end else if ({HADDR, HTRANS, HWRITE, HSIZE, HBURST} !==
                                 {e_addr[k], e_trans[k], wr, e_sz, e_bst}) begin
                        n_fail++;
                        $display("FAIL addr_phase: beat %0d got %h/%b/%b/%0d/%b expected %h/%b/%b/%0d/%b",
                                 k, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
                                 e_addr[k], e_trans[k], wr, e_sz, e_bst);
                    end
                end
                if (HTRANS !== 2'b00 && HREADY && k < e_nb) begin
                    dp = 1; di = k; dw = ws[k]; esn = 0; k++;
                end else if (done) begin
                    dp = 0;
                end
                due = done;
            end
        end
        HREADY = 1'b1; HRESP = 1'b0;
        n_chk++;
        if (!fin || k != e_n) begin
            n_fail++;
            $display("FAIL cmd_complete: got finished=%0d beats=%0d expected finished=1 beats=%0d",
                     fin, k, e_n);
        end
    endtask

    task automatic test_reset;
        HResetn = 1'b1;
        repeat (2) @(negedge Hclk);
        n_chk++;
        if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, cmd_ready,
             rsp_valid, rsp_rdata, rsp_err, rsp_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got trans=%b addr=%h wdata=%h rdy=%b rsp=%b expected all zero",
                     HTRANS, HADDR, HWDATA, cmd_ready, rsp_valid);
        end
        n_chk++;
        if ({HPROT, HMASTLOCK, HNONSEC, HEXCL, HMASTER} !== {4'b0011, 3'b000, 4'hA}) begin
            n_fail++;
            $display("FAIL constants: got prot=%b lock=%b nsec=%b excl=%b master=%h expected 0011/0/0/0/a",
                     HPROT, HMASTLOCK, HNONSEC, HEXCL, HMASTER);
        end
        HResetn = 1'b0;
        #1;
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_single_write;
        rand_slave(0);
        run_cmd(1'b1, 32'h100, 3'd2, 1'b0, {96'h0, 32'hDEADBEEF}, -1, 0);
    endtask

    task automatic test_incr4_read;
        rand_slave(0);
        rd_val[0] = 32'h11; rd_val[1] = 32'h22; rd_val[2] = 32'h33; rd_val[3] = 32'h44;
        run_cmd(1'b0, 32'h200, 3'd2, 1'b1, 128'h0, -1, 0);
    endtask

    task automatic test_wait_states;
        rand_slave(0);
        ws[0] = 3;
        run_cmd(1'b1, 32'h344, 3'd2, 1'b0, {$urandom, $urandom, $urandom, $urandom}, -1, 0);
        ws[0] = 1; ws[1] = 2; ws[2] = 0; ws[3] = 3;
        run_cmd(1'b1, 32'h1000, 3'd1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 0);
    endtask

    task automatic test_error;
        rand_slave(0);
        run_cmd(1'b0, 32'h200, 3'd2, 1'b1, 128'h0, 1, 0);
        run_cmd(1'b1, 32'h80, 3'd2, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    endtask

    task automatic test_boundary_reset;
        rand_slave(0);
        run_cmd(1'b1, 32'h3F8, 3'd2, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 0);
        ws[0] = 1; ws[1] = 1; ws[2] = 1; ws[3] = 1;
        run_cmd(1'b1, 32'h3F8, 3'd2, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 3);
        for (int i = 0; i < 2; i++) begin
            @(negedge Hclk);
            n_chk++;
            if ({rsp_valid, HTRANS, cmd_ready} !== 4'b0000) begin
                n_fail++;
                $display("FAIL in_reset: got rsp=%b trans=%b rdy=%b expected 0/00/0",
                         rsp_valid, HTRANS, cmd_ready);
            end
        end
        HResetn = 1'b0;
        #1;
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_abort: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_back_to_back;
        rand_slave(1);
        run_cmd(1'b0, 32'h13, 3'd0, 1'b1, 128'h0, -1, 0);
        run_cmd(1'b0, 32'h1007, 3'd3, 1'b0, 128'h0, -1, 0);
        run_cmd(1'b1, 32'h3FF, 3'd1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, -1, 0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic        bu;
        int          eb;
        for (int n = 0; n < 30; n++) begin
            rand_slave(2);
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[9:0] = 10'h3F0 + 10'($urandom_range(0, 15));
            bu = 1'($urandom_range(0, 1));
            eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, bu ? 3 : 0) : -1;
            run_cmd(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 3)), bu,
                    {$urandom, $urandom, $urandom, $urandom}, eb, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_write;
        test_incr4_read;
        test_wait_states;
        test_error;
        test_boundary_reset;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb5_interface.md
AHB5_INTERFACE -- requirements
Module: ahb5_interface

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width (32 only); HMASTER_ID, default 4'h0, value driven on HMASTER.
REQ-002 One clock; reset is asynchronous and active-high (port names Hclk / HResetn as in the codebase; HResetn=1 means reset asserted).
REQ-003 Hclk  in  1  system clock, all state on rising edge.
REQ-004 HResetn  in  1  asynchronous active-high reset.
REQ-005 cmd_valid in 1, cmd_ready out 1: command handshake; transfer accepted when both high at a rising edge.
REQ-006 cmd_write in 1 (1=write); cmd_addr in ADDR_W; cmd_size in 3 (HSIZE encoding, 0..2 legal); cmd_burst in 1 (0=SINGLE, 1=INCR4); cmd_wdata in 4*DATA_W (beat n = slice n).
REQ-007 rsp_valid out 1 (one-cycle pulse per completed beat); rsp_rdata out DATA_W; rsp_err out 1; rsp_last out 1 (final beat of command).
REQ-008 AHB5 outputs: HADDR ADDR_W, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HWDATA DATA_W, HMASTLOCK 1, HNONSEC 1, HEXCL 1, HMASTER 4.
REQ-009 AHB5 inputs: HRDATA DATA_W, HREADY 1, HRESP 1, HEXOKAY 1 (ignored).

Function
REQ-010 States IDLE, ADDR, DATA, ERR; cmd_ready=1 only in IDLE.
REQ-011 Accept at edge T -> first address phase driven from T+1: HTRANS=NONSEQ(2'b10), HADDR=cmd_addr with low cmd_size bits cleared, HWRITE, HSIZE, HBURST=000 (SINGLE) or 011 (INCR4).
REQ-012 Address phase completes at an edge with HREADY=1; all address-phase outputs held stable while HREADY=0.
REQ-013 INCR4: beats 2..4 use HTRANS=SEQ(2'b11), HADDR incremented by (1<<HSIZE); address of beat n+1 overlaps data phase of beat n (pipelined).
REQ-014 1 KB boundary: a beat whose HADDR[9:0] wraps to 0 is issued as NONSEQ; burst otherwise continues.
REQ-015 HWDATA for a write beat driven in the cycle after its address phase completes, held while HREADY=0; HWDATA=0 during reads and idle.
REQ-016 Read beat completes at edge with HREADY=1 and HRESP=0 -> next cycle rsp_valid=1, rsp_rdata=HRDATA sampled, rsp_err=0; write beat same with rsp_rdata=0.
REQ-017 rsp_last=1 with rsp_valid on beat 1 of SINGLE and beat 4 of INCR4.
REQ-018 Error: HRESP=1 with HREADY=0 (first error cycle) -> next cycle HTRANS=IDLE (remaining beats cancelled); at second error cycle (HREADY=1, HRESP=1) rsp_valid=1, rsp_err=1, rsp_last=1; then IDLE.
REQ-019 After last data phase completes, HTRANS=IDLE; return to IDLE; next command accepted earliest same cycle rsp_last pulses.
REQ-020 Constants: HPROT=4'b0011, HMASTLOCK=0, HNONSEC=0, HEXCL=0, HMASTER=HMASTER_ID.
REQ-021 HTRANS=BUSY (2'b01) never generated; cmd_size>2 treated as 2.
REQ-022 cmd_valid while cmd_ready=0 is ignored (not queued); command fields sampled only at acceptance.

Reset
REQ-023 While HResetn=1: state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_last=0.
REQ-024 Reset mid-burst aborts immediately (asynchronously) to reset values; no response emitted for the aborted command.
REQ-025 First command accepted at earliest on first rising edge after HResetn deasserts (cmd_ready=1 from that cycle).

Verification
REQ-026 SINGLE write addr 0x100, size 2, data 0xDEADBEEF, HREADY=1 -> one NONSEQ at 0x100, HWDATA=0xDEADBEEF next cycle, rsp_valid/rsp_last once, rsp_err=0.
REQ-027 INCR4 read addr 0x200, size 2, slave returns 0x11,0x22,0x33,0x44 -> HADDR 0x200/204/208/20C, HTRANS NONSEQ,SEQ,SEQ,SEQ, four rsp_valid pulses with those data, rsp_last on 4th.
REQ-028 SINGLE write with HREADY low 3 cycles in data phase -> HWDATA and next HTRANS stable for all 3 cycles; single response after HREADY=1.
REQ-029 INCR4 read with HRESP error on beat 2 -> HTRANS=IDLE the cycle after first error cycle, beats 3-4 never issued, rsp_err=1 with rsp_last=1.
REQ-030 INCR4 at 0x3F8 size 2 -> beat at 0x400 issued NONSEQ; reset asserted mid-burst -> all outputs return to REQ-023 values immediately.
